// File: rtl/sroot_pkg.sv
// rtl/sroot_pkg.sv - shared types and Q-format constants for the sroot controller
package sroot_pkg;
  localparam int W_CORE = 20;
  localparam int W_IN   = 16;

  localparam logic [W_CORE-1:0] QUARTER   = 20'h04000;
  localparam logic [31:0]       TWO_Q16   = 32'h0002_0000;
  localparam logic [17:0]       INV_K_DEF = 18'h1351F;

  typedef enum logic [2:0] {
    IDLE,
    NORM,
    LOAD,
    RUN,
    MUL,
    SHIFT,
    OUT
  } state_t;
endpackage

// File: rtl/sroot_if.sv
// rtl/sroot_if.sv - operand/result handshake plus CORDIC core seed/result lines
interface sroot_if;
  import sroot_pkg::*;

  logic              in_valid;
  logic              in_ready;
  logic [W_IN-1:0]   din;
  logic              out_valid;
  logic              out_ready;
  logic [15:0]       dout;
  logic              err;
  logic [W_CORE-1:0] x0;
  logic [W_CORE-1:0] y0;
  logic              s;
  logic [W_CORE-1:0] xn;
  logic [3:0]        seq;

  modport slave (
    input  in_valid, din, out_ready, xn, seq,
    output in_ready, out_valid, dout, err, x0, y0, s
  );

  modport master (
    output in_valid, din, out_ready, xn, seq,
    input  in_ready, out_valid, dout, err, x0, y0, s
  );
endinterface

// File: rtl/sroot_post.sv
// rtl/sroot_post.sv - gain removal, 2^k rescale, round-half-up and saturate to Q8.8
module sroot_post
  import sroot_pkg::*;
#(
  parameter logic [17:0] INV_K = INV_K_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [W_CORE-1:0] xn,
  input  logic [3:0]        k,
  output logic [15:0]       dout,
  output logic              done
);
  logic [37:0] p;
  logic [3:0]  k_q;
  logic        v;
  logic [4:0]  sh;
  logic [37:0] ph;
  logic [37:0] rnd;
  logic        sat;

  // ph[0] is the rounding bit p[23-k]; the rest is the truncated Q8.8 value
  always_comb begin
    sh  = 5'd23 - {1'b0, k_q};
    ph  = p >> sh;
    rnd = (ph >> 1) + {37'b0, ph[0]};
    sat = |rnd[37:16];
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      p    <= '0;
      k_q  <= '0;
      v    <= 1'b0;
      dout <= '0;
      done <= 1'b0;
    end else begin
      v    <= start;
      done <= v;
      if (start) begin
        p   <= {18'b0, xn} * {20'b0, INV_K};
        k_q <= k;
      end
      if (v) dout <= sat ? 16'hFFFF : rnd[15:0];
    end
  end
endmodule

// File: rtl/sroot_ctrl.sv
// rtl/sroot_ctrl.sv - range reduction, core sequencing and result handshake
module sroot_ctrl
  import sroot_pkg::*;
#(
  parameter logic [3:0]  DONE_SEQ = 4'd15,
  parameter int          LOAD_CYC = 2,
  parameter logic [17:0] INV_K    = INV_K_DEF,
  parameter int          TIMEOUT  = 64
) (
  input logic   clk,
  input logic   reset,
  sroot_if.slave bus
);
  state_t            state;
  logic [31:0]       r;
  logic [3:0]        k;
  logic [3:0]        lcnt;
  logic [7:0]        wd;
  logic              in_ready_q, out_valid_q, err_q, s_q;
  logic [15:0]       dout_q;
  logic [W_CORE-1:0] x0_q, y0_q;
  logic              post_start, post_done;
  logic [15:0]       post_dout;

  // Multiply issues on the RUN exit edge so the product is registered during MUL
  assign post_start = (state == RUN) && (bus.seq == DONE_SEQ);

  sroot_post #(.INV_K(INV_K)) u_post (
    .clk   (clk),
    .reset (reset),
    .start (post_start),
    .xn    (bus.xn),
    .k     (k),
    .dout  (post_dout),
    .done  (post_done)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      r           <= '0;
      k           <= '0;
      lcnt        <= '0;
      wd          <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      err_q       <= 1'b0;
      dout_q      <= '0;
      s_q         <= 1'b1;
      x0_q        <= '0;
      y0_q        <= '0;
    end else begin
      case (state)
        IDLE: if (bus.in_valid) begin
          r          <= {bus.din, 16'h0};
          k          <= '0;
          in_ready_q <= 1'b0;
          err_q      <= 1'b0;
          if (bus.din == '0) begin
            dout_q      <= '0;
            out_valid_q <= 1'b1;
            state       <= OUT;
          end else begin
            state <= NORM;
          end
        end
        NORM: if (r >= TWO_Q16) begin
          r <= r >> 2;
          k <= k + 4'd1;
        end else begin
          x0_q  <= r[W_CORE-1:0] + QUARTER;
          y0_q  <= r[W_CORE-1:0] - QUARTER;
          lcnt  <= '0;
          state <= LOAD;
        end
        LOAD: if (lcnt == 4'(LOAD_CYC - 1)) begin
          s_q   <= 1'b0;
          wd    <= '0;
          state <= RUN;
        end else begin
          lcnt <= lcnt + 4'd1;
        end
        RUN: if (bus.seq == DONE_SEQ) begin
          state <= MUL;
        end else if (wd == 8'(TIMEOUT - 1)) begin
          err_q       <= 1'b1;
          dout_q      <= 16'hFFFF;
          out_valid_q <= 1'b1;
          state       <= OUT;
        end else begin
          wd <= wd + 8'd1;
        end
        MUL: state <= SHIFT;
        SHIFT: if (post_done) begin
          dout_q      <= post_dout;
          out_valid_q <= 1'b1;
          state       <= OUT;
        end
        OUT: if (bus.out_ready) begin
          out_valid_q <= 1'b0;
          in_ready_q  <= 1'b1;
          s_q         <= 1'b1;
          state       <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.dout      = dout_q;
  assign bus.err       = err_q;
  assign bus.x0        = x0_q;
  assign bus.y0        = y0_q;
  assign bus.s         = s_q;
endmodule
